// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, FSM state encoding and owner type for mem_arbiter
package mem_arbiter_pkg;
  localparam int ARB_WORD_SIZE = 16;
  localparam int ARB_LINE_WORDS = 4;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;
endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: two-way priority select; ptr=1 favours D, ptr=0 favours I (ports: req_i, req_d, ptr in; winner out)
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  logic   ptr,
  output owner_t winner
);
  assign winner = (req_d && (ptr || !req_i)) ? OWN_D : OWN_I;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: I/D line-burst arbiter for one memory port (ports: clk, reset, i_* I-side, d_* D-side, m_* memory); ARB_ROUND_ROBIN_EN selects round-robin over fixed D priority
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WORD_SIZE  = ARB_WORD_SIZE,
  parameter int LINE_WORDS = ARB_LINE_WORDS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_req,
  input  logic [WORD_SIZE-1:0]            i_addr,
  output logic                            i_grant,
  output logic                            i_rvalid,
  output logic [WORD_SIZE-1:0]            i_rdata,
  output logic [$clog2(LINE_WORDS)-1:0]   i_beat,
  output logic                            i_done,
  input  logic                            d_req,
  input  logic                            d_we,
  input  logic [WORD_SIZE-1:0]            d_addr,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] d_wdata,
  output logic                            d_grant,
  output logic                            d_rvalid,
  output logic [WORD_SIZE-1:0]            d_rdata,
  output logic [$clog2(LINE_WORDS)-1:0]   d_beat,
  output logic                            d_done,
  output logic                            m_req,
  output logic                            m_we,
  output logic [WORD_SIZE-1:0]            m_addr,
  output logic [WORD_SIZE-1:0]            m_wdata,
  input  logic [WORD_SIZE-1:0]            m_rdata,
  input  logic                            m_ack
);
  localparam int BW = $clog2(LINE_WORDS);
  logic [1:0]              r_state;
  owner_t                  r_owner;
  logic [WORD_SIZE-BW-1:0] r_line;
  logic                    r_we;
  logic [BW-1:0]           r_beat;
  logic                    w_ptr;
  owner_t                  w_winner;
  logic                    w_pick_d;
  logic                    w_busy_i;
  logic                    w_busy_d;
  logic                    w_busy;
  logic                    w_done;
  logic                    w_unused;

  assign w_unused = ^{i_addr[BW-1:0], d_addr[BW-1:0]};

  arb_pick u_pick (
    .req_i  (i_req),
    .req_d  (d_req),
    .ptr    (w_ptr),
    .winner (w_winner)
  );

  assign w_pick_d = (w_winner == OWN_D);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_ptr;
  // After a burst, favour whichever side did not own it.
  always_ff @(posedge clk or posedge reset)
    if (reset) r_ptr <= 1'b1;
    else if (r_state == ST_DONE) r_ptr <= (r_owner == OWN_I);
  assign w_ptr = r_ptr;
`else
  assign w_ptr = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_I;
      r_line  <= '0;
      r_we    <= 1'b0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_req || d_req) begin
          r_state <= w_pick_d ? ST_BUSY_D : ST_BUSY_I;
          r_owner <= w_winner;
          r_line  <= w_pick_d ? d_addr[WORD_SIZE-1:BW] : i_addr[WORD_SIZE-1:BW];
          r_we    <= w_pick_d && d_we;
          r_beat  <= '0;
        end
        ST_BUSY_I, ST_BUSY_D: if (m_ack) begin
          r_beat <= r_beat + BW'(1);
          if (&r_beat) r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end

  assign w_busy_i = (r_state == ST_BUSY_I);
  assign w_busy_d = (r_state == ST_BUSY_D);
  assign w_busy   = w_busy_i || w_busy_d;
  assign w_done   = (r_state == ST_DONE);

  assign i_grant  = w_busy_i || (w_done && r_owner == OWN_I);
  assign i_rvalid = w_busy_i && m_ack;
  assign i_rdata  = i_rvalid ? m_rdata : '0;
  assign i_beat   = w_busy_i ? r_beat : '0;
  assign i_done   = w_done && r_owner == OWN_I;

  assign d_grant  = w_busy_d || (w_done && r_owner == OWN_D);
  assign d_rvalid = w_busy_d && m_ack && !r_we;
  assign d_rdata  = d_rvalid ? m_rdata : '0;
  assign d_beat   = w_busy_d ? r_beat : '0;
  assign d_done   = w_done && r_owner == OWN_D;

  assign m_req   = w_busy;
  assign m_we    = w_busy && r_we;
  assign m_addr  = w_busy ? {r_line, r_beat} : '0;
  assign m_wdata = m_we ? d_wdata[r_beat*WORD_SIZE +: WORD_SIZE] : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table, hand-written corner sequences and randomized transactions against a transaction-level model
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_grant, i_rvalid, i_done;
  logic [15:0] i_addr, i_rdata;
  logic [1:0]  i_beat;
  logic        d_req, d_we, d_grant, d_rvalid, d_done;
  logic [15:0] d_addr, d_rdata;
  logic [63:0] d_wdata;
  logic [1:0]  d_beat;
  logic        m_req, m_we, m_ack;
  logic [15:0] m_addr, m_wdata, m_rdata;
  int total = 0;
  int passed = 0;
  bit fav_d;

  typedef struct packed {
    logic        i_req;
    logic        ack;
    logic [15:0] rdata;
    logic        e_mreq;
    logic [15:0] e_maddr;
    logic        e_grant;
    logic        e_rvalid;
    logic [1:0]  e_beat;
    logic        e_done;
  } vec_t;
  vec_t tv [10];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_beat(i_beat), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_beat(d_beat), .d_done(d_done),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic raise_i();
    i_req  = 1'b1;
    i_addr = 16'($urandom);
  endtask

  task automatic raise_d();
    d_req   = 1'b1;
    d_addr  = 16'($urandom);
    d_we    = 1'($urandom_range(0, 1));
    d_wdata = {$urandom, $urandom};
  endtask

  // Entered in an IDLE cycle with requests already driven; returns inside the DONE cycle.
  task automatic run_txn(input bit wd, input logic [15:0] line, input bit we, input logic [63:0] wdata);
    int  w;
    bit  a, rv;
    m_ack   = 1'($urandom_range(0, 1));
    m_rdata = 16'($urandom);
    #1;
    chk("idle_mreq", m_req, 0);
    chk("idle_grant", {i_grant, d_grant}, 0);
    chk("idle_rvalid", {i_rvalid, d_rvalid}, 0);
    chk("idle_done", {i_done, d_done}, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      w = $urandom_range(0, 2);
      for (int c = 0; c <= w; c++) begin
        a = (c == w);
        m_ack   = a;
        m_rdata = 16'($urandom);
        #1;
        rv = a && !we;
        chk("busy_grant", {i_grant, d_grant}, wd ? 2'b01 : 2'b10);
        chk("busy_mreq", m_req, 1);
        chk("busy_mwe", m_we, we);
        chk("busy_maddr", m_addr, line | 16'(k));
        chk("busy_mwdata", m_wdata, we ? wdata[16*k +: 16] : 16'h0);
        chk("busy_rvalid", {i_rvalid, d_rvalid}, {!wd && rv, wd && rv});
        chk("busy_i_rdata", i_rdata, (!wd && rv) ? m_rdata : 16'h0);
        chk("busy_d_rdata", d_rdata, (wd && rv) ? m_rdata : 16'h0);
        chk("nonowner_beat", wd ? i_beat : d_beat, 0);
        if (rv) chk("owner_beat", wd ? d_beat : i_beat, k);
        chk("busy_done", {i_done, d_done}, 0);
        step();
      end
    end
    m_ack   = 1'($urandom_range(0, 1));
    m_rdata = 16'($urandom);
    #1;
    chk("done_pulse", {i_done, d_done}, wd ? 2'b01 : 2'b10);
    chk("done_grant", {i_grant, d_grant}, wd ? 2'b01 : 2'b10);
    chk("done_mreq", m_req, 0);
    chk("done_rvalid", {i_rvalid, d_rvalid}, 0);
  endtask

  initial begin
    bit wd;
    logic [1:0] r;
    reset = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    m_ack = 0; m_rdata = 0;
    fav_d = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_outs", {i_grant, i_rvalid, i_done, d_grant, d_rvalid, d_done, m_req, m_we}, 0);
    chk("rst_buses", {m_addr, m_wdata, i_rdata, d_rdata, i_beat, d_beat}, 0);

    // both requesters raised on the same edge and held through two bursts
    i_req = 1; i_addr = 16'h1000; d_req = 1; d_addr = 16'h2000; d_we = 0;
    run_txn(1'b1, 16'h2000, 1'b0, 64'h0);
    step();
`ifdef ARB_ROUND_ROBIN_EN
    run_txn(1'b0, 16'h1000, 1'b0, 64'h0);
`else
    run_txn(1'b1, 16'h2000, 1'b0, 64'h0);
`endif
    i_req = 0; d_req = 0;
    fav_d = 1'b1;
    step();

    // I-side read of 0x0123 with a three-cycle stall before beat 1
    tv[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0};
    tv[1] = '{1'b1, 1'b1, 16'hA000, 1'b1, 16'h0120, 1'b1, 1'b1, 2'd0, 1'b0};
    tv[2] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0121, 1'b1, 1'b0, 2'd1, 1'b0};
    tv[3] = tv[2];
    tv[4] = tv[2];
    tv[5] = '{1'b1, 1'b1, 16'hA001, 1'b1, 16'h0121, 1'b1, 1'b1, 2'd1, 1'b0};
    tv[6] = '{1'b1, 1'b1, 16'hA002, 1'b1, 16'h0122, 1'b1, 1'b1, 2'd2, 1'b0};
    tv[7] = '{1'b1, 1'b1, 16'hA003, 1'b1, 16'h0123, 1'b1, 1'b1, 2'd3, 1'b0};
    tv[8] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1};
    tv[9] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0};
    i_addr = 16'h0123;
    for (int n = 0; n < 10; n++) begin
      i_req = tv[n].i_req; m_ack = tv[n].ack; m_rdata = tv[n].rdata;
      #1;
      chk($sformatf("tv%0d_mreq", n), m_req, tv[n].e_mreq);
      if (tv[n].e_mreq) chk($sformatf("tv%0d_maddr", n), m_addr, tv[n].e_maddr);
      chk($sformatf("tv%0d_igrant", n), i_grant, tv[n].e_grant);
      chk($sformatf("tv%0d_irvalid", n), i_rvalid, tv[n].e_rvalid);
      if (tv[n].e_rvalid) chk($sformatf("tv%0d_idata", n), {i_rdata, i_beat}, {tv[n].rdata, tv[n].e_beat});
      chk($sformatf("tv%0d_idone", n), i_done, tv[n].e_done);
      chk($sformatf("tv%0d_dside", n), {d_grant, d_rvalid, d_done}, 0);
      step();
    end

    // D-side write-back of a full line
    d_req = 1; d_we = 1; d_addr = 16'h0040; d_wdata = 64'h4444_3333_2222_1111;
    run_txn(1'b1, 16'h0040, 1'b1, 64'h4444_3333_2222_1111);
    d_req = 0;
`ifdef ARB_ROUND_ROBIN_EN
    fav_d = 1'b0;
`endif
    step();

    // reset while BUSY_D sits at beat 2
    d_req = 1; d_we = 0; d_addr = 16'h0200; m_ack = 0;
    step();
    m_ack = 1;
    step();
    step();
    #1;
    chk("pre_rst_beat", {d_rvalid, d_beat}, {1'b1, 2'd2});
    reset = 1'b1;
    #1;
    chk("mid_rst_outs", {d_grant, d_rvalid, d_done, m_req, m_we, i_grant}, 0);
    chk("mid_rst_buses", {m_addr, d_rdata, d_beat}, 0);
    m_ack = 0;
    step();
    chk("in_rst_done", d_done, 0);
    reset = 1'b0;
    fav_d = 1'b1;
    run_txn(1'b1, 16'h0200, 1'b0, 64'h0);
    d_req = 0;
`ifdef ARB_ROUND_ROBIN_EN
    fav_d = 1'b0;
`endif
    step();

    // randomized transactions against the priority model
    for (int t = 0; t < 40; t++) begin
      if (!i_req && !d_req) begin
        r = 2'($urandom_range(1, 3));
        if (r[0]) raise_i();
        if (r[1]) raise_d();
      end else if (!i_req && $urandom_range(0, 2) == 0) raise_i();
      else if (!d_req && $urandom_range(0, 2) == 0) raise_d();
      wd = (i_req && d_req) ? fav_d : d_req;
      run_txn(wd, wd ? (d_addr & 16'hFFFC) : (i_addr & 16'hFFFC), wd && d_we, d_wdata);
      if (wd) d_req = 0;
      else i_req = 0;
`ifdef ARB_ROUND_ROBIN_EN
      fav_d = !wd;
`endif
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
